// File: rtl/control_unit.sv
// Hardwired MiniSRC control sequencer: RST/T0-T7/HALT state machine that
// decodes state, ir[31:27] and con into every datapath control strobe.
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con,
    input  logic        stop,
    output logic        run,
    output logic [7:0]  out_sel,
    output logic [8:0]  in_sel,
    output logic [5:0]  gpr_ctl,
    output logic [1:0]  mem_ctl,
    output logic        inc_pc,
    output logic        con_in,
    output logic        r15_in,
    output logic [4:0]  ops
);

    localparam logic [4:0] ADD_OP = 5'b00011;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int unsigned PC_OUT   = 0;
    localparam int unsigned MDR_OUT  = 1;
    localparam int unsigned RZHI_OUT = 2;
    localparam int unsigned RZLO_OUT = 3;
    localparam int unsigned HI_OUT   = 4;
    localparam int unsigned LO_OUT   = 5;
    localparam int unsigned PORT_OUT = 6;
    localparam int unsigned C_OUT    = 7;

    localparam int unsigned PC_IN   = 0;
    localparam int unsigned IR_IN   = 1;
    localparam int unsigned MAR_IN  = 2;
    localparam int unsigned MDR_IN  = 3;
    localparam int unsigned RY_IN   = 4;
    localparam int unsigned RZ_IN   = 5;
    localparam int unsigned HI_IN   = 6;
    localparam int unsigned LO_IN   = 7;
    localparam int unsigned PORT_IN = 8;

    localparam int unsigned GRA    = 0;
    localparam int unsigned GRB    = 1;
    localparam int unsigned GRC    = 2;
    localparam int unsigned RIN    = 3;
    localparam int unsigned ROUT   = 4;
    localparam int unsigned BA_OUT = 5;

    localparam int unsigned MEM_RD = 0;
    localparam int unsigned MEM_WR = 1;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     state_q;
    logic [4:0] op;
    logic       unused_ir;

    assign op        = ir[31:27];
    assign unused_ir = ^ir[26:0];

    // Final step of each instruction; nop and undefined opcodes end at T2.
    function automatic state_t last_step(input logic [4:0] opc);
        case (opc) inside
            OP_LD, OP_ST:                            last_step = S_T7;
            OP_LDI, [5'd3:5'd14]:                    last_step = S_T5;
            OP_MUL, OP_DIV, OP_BR:                   last_step = S_T6;
            OP_NEG, OP_NOT, OP_JAL:                  last_step = S_T4;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:  last_step = S_T3;
            default:                                 last_step = S_T2;
        endcase
    endfunction

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_RST;
        end else begin
            case (state_q)
                S_RST:  state_q <= S_T0;
                S_HALT: state_q <= S_HALT;
                default: begin
                    if (state_q == S_T2 && op == OP_HALT) begin
                        state_q <= S_HALT;
                    end else if (state_q == last_step(op)) begin
                        state_q <= stop ? S_HALT : S_T0;
                    end else begin
                        state_q <= state_t'(state_q + 4'd1);
                    end
                end
            endcase
        end
    end

    // Moore decode of state/opcode/con into strobes.
    always_comb begin
        run     = 1'b0;
        out_sel = '0;
        in_sel  = '0;
        gpr_ctl = '0;
        mem_ctl = '0;
        inc_pc  = 1'b0;
        con_in  = 1'b0;
        r15_in  = 1'b0;
        ops     = '0;
        if (state_q != S_RST && state_q != S_HALT) begin
            run = 1'b1;
        end
        case (state_q)
            S_T0: begin
                out_sel[PC_OUT] = 1'b1;
                in_sel[MAR_IN]  = 1'b1;
                inc_pc          = 1'b1;
            end
            S_T1: begin
                mem_ctl[MEM_RD] = 1'b1;
                in_sel[MDR_IN]  = 1'b1;
            end
            S_T2: begin
                out_sel[MDR_OUT] = 1'b1;
                in_sel[IR_IN]    = 1'b1;
            end
            S_T3: begin
                case (op) inside
                    OP_LD, OP_LDI, OP_ST: begin
                        gpr_ctl[GRB] = 1'b1; gpr_ctl[BA_OUT] = 1'b1; in_sel[RY_IN] = 1'b1;
                    end
                    [5'd3:5'd14]: begin
                        gpr_ctl[GRB] = 1'b1; gpr_ctl[ROUT] = 1'b1; in_sel[RY_IN] = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        gpr_ctl[GRA] = 1'b1; gpr_ctl[ROUT] = 1'b1; in_sel[RY_IN] = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin
                        gpr_ctl[GRB] = 1'b1; gpr_ctl[ROUT] = 1'b1;
                        ops = op; in_sel[RZ_IN] = 1'b1;
                    end
                    OP_BR: begin
                        gpr_ctl[GRA] = 1'b1; gpr_ctl[ROUT] = 1'b1; con_in = 1'b1;
                    end
                    OP_JR: begin
                        gpr_ctl[GRA] = 1'b1; gpr_ctl[ROUT] = 1'b1; in_sel[PC_IN] = 1'b1;
                    end
                    OP_JAL: begin
                        out_sel[PC_OUT] = 1'b1; r15_in = 1'b1;
                    end
                    OP_IN: begin
                        out_sel[PORT_OUT] = 1'b1; gpr_ctl[GRA] = 1'b1; gpr_ctl[RIN] = 1'b1;
                    end
                    OP_OUT: begin
                        gpr_ctl[GRA] = 1'b1; gpr_ctl[ROUT] = 1'b1; in_sel[PORT_IN] = 1'b1;
                    end
                    OP_MFHI: begin
                        out_sel[HI_OUT] = 1'b1; gpr_ctl[GRA] = 1'b1; gpr_ctl[RIN] = 1'b1;
                    end
                    OP_MFLO: begin
                        out_sel[LO_OUT] = 1'b1; gpr_ctl[GRA] = 1'b1; gpr_ctl[RIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (op) inside
                    OP_LD, OP_LDI, OP_ST: begin
                        out_sel[C_OUT] = 1'b1; ops = ADD_OP; in_sel[RZ_IN] = 1'b1;
                    end
                    [5'd3:5'd11]: begin
                        gpr_ctl[GRC] = 1'b1; gpr_ctl[ROUT] = 1'b1;
                        ops = op; in_sel[RZ_IN] = 1'b1;
                    end
                    [5'd12:5'd14]: begin
                        out_sel[C_OUT] = 1'b1; ops = op; in_sel[RZ_IN] = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        gpr_ctl[GRB] = 1'b1; gpr_ctl[ROUT] = 1'b1;
                        ops = op; in_sel[RZ_IN] = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin
                        out_sel[RZLO_OUT] = 1'b1; gpr_ctl[GRA] = 1'b1; gpr_ctl[RIN] = 1'b1;
                    end
                    OP_BR: begin
                        out_sel[PC_OUT] = 1'b1; in_sel[RY_IN] = 1'b1;
                    end
                    OP_JAL: begin
                        gpr_ctl[GRA] = 1'b1; gpr_ctl[ROUT] = 1'b1; in_sel[PC_IN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op) inside
                    OP_LD, OP_ST: begin
                        out_sel[RZLO_OUT] = 1'b1; in_sel[MAR_IN] = 1'b1;
                    end
                    OP_LDI, [5'd3:5'd14]: begin
                        out_sel[RZLO_OUT] = 1'b1; gpr_ctl[GRA] = 1'b1; gpr_ctl[RIN] = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        out_sel[RZLO_OUT] = 1'b1; in_sel[LO_IN] = 1'b1;
                    end
                    OP_BR: begin
                        out_sel[C_OUT] = 1'b1; ops = ADD_OP; in_sel[RZ_IN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (op)
                    OP_LD: begin
                        mem_ctl[MEM_RD] = 1'b1; in_sel[MDR_IN] = 1'b1;
                    end
                    OP_ST: begin
                        gpr_ctl[GRA] = 1'b1; gpr_ctl[ROUT] = 1'b1; in_sel[MDR_IN] = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        out_sel[RZHI_OUT] = 1'b1; in_sel[HI_IN] = 1'b1;
                    end
                    OP_BR: begin
                        // Branch target is committed only when CON is set.
                        out_sel[RZLO_OUT] = con;
                        in_sel[PC_IN]     = con;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (op)
                    OP_LD: begin
                        out_sel[MDR_OUT] = 1'b1; gpr_ctl[GRA] = 1'b1; gpr_ctl[RIN] = 1'b1;
                    end
                    OP_ST:   mem_ctl[MEM_WR] = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed per-step expectations are queued
// by the stimulus thread and checked by a negedge monitor.
module tb_control_unit;

    logic        clock;
    logic        clear;
    logic [31:0] ir;
    logic        con;
    logic        stop;
    logic        run;
    logic [7:0]  out_sel;
    logic [8:0]  in_sel;
    logic [5:0]  gpr_ctl;
    logic [1:0]  mem_ctl;
    logic        inc_pc;
    logic        con_in;
    logic        r15_in;
    logic [4:0]  ops;

    control_unit dut (
        .clock   (clock),
        .clear   (clear),
        .ir      (ir),
        .con     (con),
        .stop    (stop),
        .run     (run),
        .out_sel (out_sel),
        .in_sel  (in_sel),
        .gpr_ctl (gpr_ctl),
        .mem_ctl (mem_ctl),
        .inc_pc  (inc_pc),
        .con_in  (con_in),
        .r15_in  (r15_in),
        .ops     (ops)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [33:0] exp_q[$];
    string       nm_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Packs {run,out_sel,in_sel,gpr_ctl,mem_ctl,inc_pc,con_in,r15_in,ops}.
    function automatic logic [33:0] e(input logic r, input logic [7:0] o, input logic [8:0] i,
                                      input logic [5:0] g, input logic [1:0] m, input logic inc,
                                      input logic ci, input logic r15, input logic [4:0] op);
        return {r, o, i, g, m, inc, ci, r15, op};
    endfunction

    localparam logic [33:0] E0 = 34'd0;

    task automatic cyc(input logic [33:0] ev, input string nm);
        exp_q.push_back(ev);
        nm_q.push_back(nm);
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input string tag);
        cyc(e(1, 8'h01, 9'h004, 6'h00, 2'b00, 1, 0, 0, 5'd0), {tag, "_T0"});
        cyc(e(1, 8'h00, 9'h008, 6'h00, 2'b01, 0, 0, 0, 5'd0), {tag, "_T1"});
        cyc(e(1, 8'h02, 9'h002, 6'h00, 2'b00, 0, 0, 0, 5'd0), {tag, "_T2"});
    endtask

    task automatic ldst_front(input string tag);
        cyc(e(1, 8'h00, 9'h010, 6'h22, 2'b00, 0, 0, 0, 5'd0), {tag, "_T3"});
        cyc(e(1, 8'h80, 9'h020, 6'h00, 2'b00, 0, 0, 0, 5'd3), {tag, "_T4"});
        cyc(e(1, 8'h08, 9'h004, 6'h00, 2'b00, 0, 0, 0, 5'd0), {tag, "_T5"});
    endtask

    task automatic br_seq(input logic c, input string tag);
        ir = 32'h98000000; con = c;
        fetch(tag);
        cyc(e(1, 8'h00, 9'h000, 6'h11, 2'b00, 0, 1, 0, 5'd0), {tag, "_T3"});
        cyc(e(1, 8'h01, 9'h010, 6'h00, 2'b00, 0, 0, 0, 5'd0), {tag, "_T4"});
        cyc(e(1, 8'h80, 9'h020, 6'h00, 2'b00, 0, 0, 0, 5'd3), {tag, "_T5"});
        if (c) cyc(e(1, 8'h08, 9'h001, 6'h00, 2'b00, 0, 0, 0, 5'd0), {tag, "_T6"});
        else   cyc(E0 | e(1, 8'h00, 9'h000, 6'h00, 2'b00, 0, 0, 0, 5'd0), {tag, "_T6"});
    endtask

    // Monitor: compares queued expectation and invariants each cycle.
    always @(negedge clock) begin
        logic [33:0] act;
        logic [33:0] ev;
        string       nm;
        act = {run, out_sel, in_sel, gpr_ctl, mem_ctl, inc_pc, con_in, r15_in, ops};
        if (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            nm = nm_q.pop_front();
            n_checks++;
            if (act !== ev) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", nm, act, ev);
            end
        end
        n_checks++;
        if (!$onehot0({out_sel, gpr_ctl[4]})) begin
            n_fail++;
            $display("FAIL bus_onehot: out_sel=%h rout=%b required at most one", out_sel, gpr_ctl[4]);
        end
        n_checks++;
        if (mem_ctl == 2'b11) begin
            n_fail++;
            $display("FAIL rd_wr_excl: mem_ctl=%b required not 11", mem_ctl);
        end
        n_checks++;
        if (in_sel[0] && inc_pc) begin
            n_fail++;
            $display("FAIL pcin_incpc: pcin=%b inc_pc=%b required not both", in_sel[0], inc_pc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b1; ir = 32'h0; con = 1'b0; stop = 1'b0;
        @(posedge clock); #1;
        cyc(E0, "rst_held");
        clear = 1'b0;
        cyc(E0, "rst_released");

        // add, aborted by clear in T4
        ir = 32'h18000000;
        fetch("addclr");
        cyc(e(1, 8'h00, 9'h010, 6'h12, 2'b00, 0, 0, 0, 5'd0), "addclr_T3");
        clear = 1'b1;
        #1;
        cyc(E0, "clear_midT4");
        clear = 1'b0;
        cyc(E0, "rst_after_clear");

        // full add: 6 cycles then T0
        fetch("add");
        cyc(e(1, 8'h00, 9'h010, 6'h12, 2'b00, 0, 0, 0, 5'd0), "add_T3");
        cyc(e(1, 8'h00, 9'h020, 6'h14, 2'b00, 0, 0, 0, 5'd3), "add_T4");
        cyc(e(1, 8'h08, 9'h000, 6'h09, 2'b00, 0, 0, 0, 5'd0), "add_T5");

        ir = 32'h00000000;
        fetch("ld");
        ldst_front("ld");
        cyc(e(1, 8'h00, 9'h008, 6'h00, 2'b01, 0, 0, 0, 5'd0), "ld_T6");
        cyc(e(1, 8'h02, 9'h000, 6'h09, 2'b00, 0, 0, 0, 5'd0), "ld_T7");

        ir = 32'h10000000;
        fetch("st");
        ldst_front("st");
        cyc(e(1, 8'h00, 9'h008, 6'h11, 2'b00, 0, 0, 0, 5'd0), "st_T6");
        cyc(e(1, 8'h00, 9'h000, 6'h00, 2'b10, 0, 0, 0, 5'd0), "st_T7");

        br_seq(1'b0, "br0");
        br_seq(1'b1, "br1");
        con = 1'b0;

        ir = 32'h78000000;
        fetch("mul");
        cyc(e(1, 8'h00, 9'h010, 6'h11, 2'b00, 0, 0, 0, 5'd0), "mul_T3");
        cyc(e(1, 8'h00, 9'h020, 6'h12, 2'b00, 0, 0, 0, 5'd15), "mul_T4");
        cyc(e(1, 8'h08, 9'h080, 6'h00, 2'b00, 0, 0, 0, 5'd0), "mul_T5");
        cyc(e(1, 8'h04, 9'h040, 6'h00, 2'b00, 0, 0, 0, 5'd0), "mul_T6");

        ir = 32'hA8000000;
        fetch("jal");
        cyc(e(1, 8'h01, 9'h000, 6'h00, 2'b00, 0, 0, 1, 5'd0), "jal_T3");
        cyc(e(1, 8'h00, 9'h001, 6'h11, 2'b00, 0, 0, 0, 5'd0), "jal_T4");

        // undefined opcode returns to T0 straight from T2
        ir = 32'hF8000000;
        fetch("undef");

        // mflo with stop raised during T1
        ir = 32'hC8000000;
        cyc(e(1, 8'h01, 9'h004, 6'h00, 2'b00, 1, 0, 0, 5'd0), "mflo_T0");
        stop = 1'b1;
        cyc(e(1, 8'h00, 9'h008, 6'h00, 2'b01, 0, 0, 0, 5'd0), "mflo_T1");
        cyc(e(1, 8'h02, 9'h002, 6'h00, 2'b00, 0, 0, 0, 5'd0), "mflo_T2");
        cyc(e(1, 8'h20, 9'h000, 6'h09, 2'b00, 0, 0, 0, 5'd0), "mflo_T3");
        stop = 1'b0;
        cyc(E0, "halt_after_stop");
        cyc(E0, "halt_sticky");

        clear = 1'b1;
        cyc(E0, "rst_from_halt");
        clear = 1'b0;
        cyc(E0, "rst_hold2");

        // halt opcode
        ir = 32'hD8000000;
        fetch("halt");
        cyc(E0, "halt_op");
        cyc(E0, "halt_op_sticky");

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL queue_drain: %0d left required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired control sequencer for the MiniSRC datapath. It drives every control strobe the datapath consumes: bus-out selects, register enables, the gra/grb/grc select encoder controls, memory Read/Write, IncPC, conin and the ALU op code.
- It runs a fetch/decode/execute state machine, with T0-T7 steps per instruction, keyed on IR[31:27] and the CON flag.

Parameters:
- ADD_OP, 5'b00011, ALU op code driven for address, immediate and branch-target additions.

Ports:
- clock  in  1  system clock; all state changes occur on its rising edge.
- clear  in  1  asynchronous, active-high reset.
- ir  in  32  instruction register contents; only [31:27] (opcode) is decoded.
- con  in  1  CON flip-flop output.
- stop  in  1  halt request; the current instruction completes first.
- run  out  1  high while sequencing; low in RST and HALT.
- out_sel  out  8  bus-out strobes: [0]PCout [1]MDRout [2]RZHIout [3]RZLOout [4]HIout [5]LOout [6]PORTout [7]cout.
- in_sel  out  9  load strobes: [0]PCin [1]IRin [2]MARin [3]MDRin [4]RYin [5]RZin [6]HIin [7]LOin [8]PORTin.
- gpr_ctl  out  6  [0]gra [1]grb [2]grc [3]rin [4]rout [5]BAout.
- mem_ctl  out  2  [0]Read [1]Write.
- inc_pc  out  1  IncPC.
- con_in  out  1  conin.
- r15_in  out  1  R15in (jal link).
- ops  out  5  ALU op code.

Behaviour:
- States: RST, T0-T7, HALT. The state register is the only storage.
- Outputs are a Moore-style combinational decode of state, ir[31:27] and con.
- clear asserted: state goes to RST immediately, including mid-instruction. In RST every strobe and run are 0, and ops=0.
- First rising edge with clear low: RST->T0.
- Strobes not listed in a step are 0. ops=0 except where stated.
- Fetch:
  - T0: PCout, MARin, inc_pc.
  - T1: Read, MDRin.
  - T2: MDRout, IRin.
- Opcodes and execute steps (last listed step returns to T0):
  - 00000 ld: T3 grb,BAout,RYin; T4 cout,ops=ADD_OP,RZin; T5 RZLOout,MARin; T6 Read,MDRin; T7 MDRout,gra,rin.
  - 00001 ldi: T3-T4 as ld; T5 RZLOout,gra,rin.
  - 00010 st: T3-T5 as ld; T6 gra,rout,MDRin (Read=0); T7 Write.
  - 00011-01011 R-type (add,sub,and,or,ror,rol,shr,shra,shl): T3 grb,rout,RYin; T4 grc,rout,ops=opcode,RZin; T5 RZLOout,gra,rin.
  - 01100-01110 addi/andi/ori: T3 grb,rout,RYin; T4 cout,ops=opcode,RZin; T5 RZLOout,gra,rin.
  - 01111 mul, 10000 div: T3 gra,rout,RYin; T4 grb,rout,ops=opcode,RZin; T5 RZLOout,LOin; T6 RZHIout,HIin.
  - 10001 neg, 10010 not: T3 grb,rout,ops=opcode,RZin; T4 RZLOout,gra,rin.
  - 10011 br: T3 gra,rout,con_in; T4 PCout,RYin; T5 cout,ops=ADD_OP,RZin; T6 RZLOout,PCin only if con=1, else no strobes.
  - 10100 jr: T3 gra,rout,PCin.
  - 10101 jal: T3 PCout,r15_in; T4 gra,rout,PCin.
  - 10110 in: T3 PORTout,gra,rin.
  - 10111 out: T3 gra,rout,PORTin.
  - 11000 mfhi: T3 HIout,gra,rin.
  - 11001 mflo: T3 LOout,gra,rin.
  - 11010 nop, and all undefined opcodes: T2->T0 directly, no execute step.
  - 11011 halt: T2->HALT.
- stop:
  - It is sampled only at the final step of an instruction (including nop/undefined at T2).
  - If stop=1, go to HALT instead of T0. Asserting stop during fetch does not abort the instruction.
- HALT: all strobes 0, run=0. Exited only by clear.
- Invariants, checked by bench assertions:
  - At most one of out_sel bits and rout is high per cycle.
  - Read and Write are never high together.
  - in_sel[0] is never high together with inc_pc.

Test Plan:
- clear pulsed mid-T4 of add -> state=RST and all outputs 0 in the same cycle; first edge after release gives T0 with out_sel=8'h01, in_sel[2]=1, inc_pc=1.
- ir=32'h18000000 (add) -> T3 gpr_ctl=6'b010010 with in_sel[4]; T4 gpr_ctl=6'b010100, ops=5'b00011, in_sel[5]; T5 out_sel=8'h08, gpr_ctl=6'b001001; then T0; 6 cycles total from T0.
- ir=32'h00000000 (ld) -> T6 mem_ctl=2'b01 with in_sel[3]; T7 out_sel=8'h02, gpr_ctl=6'b001001; 8 cycles total. st (32'h10000000) gives T7 mem_ctl=2'b10.
- br (32'h98000000) with con=0 at T6 -> no PCin; repeated with con=1 -> out_sel=8'h08 and in_sel[0] at T6.
- mul (32'h78000000) -> T5 in_sel[7] with out_sel=8'h08; T6 in_sel[6] with out_sel=8'h04.
- stop raised at T1 of an mflo -> T3 completes (LOout,gra,rin), then HALT with run=0. ir=32'hD8000000 (halt) -> HALT after T2. ir=32'hF8000000 (undefined) -> T2->T0.
